ispm_way_cfg_seq: RTL and testbench

Sequences reconfiguration of instruction-cache ways between cache mode and scratchpad (SPM) mode. On a configuration request it drains outstanding fetch/LSU traffic and zero-sweeps every line of each way whose mode changes, so tags read as invalid and SPM contents start at zero. It then commits the new mask onto `active_ways_o`, which feeds the ISPM controller's `active_ways_i`. Its memory port is OR-merged with the ISPM controller's way-memory port; exclusivity is guaranteed by `busy_o`.

---
 rtl/ispm_way_cfg_seq_pkg.sv | 13 +
 rtl/ispm_way_cfg_seq.sv | 123 ++++++++++++
 tb/tb_ispm_way_cfg_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ispm_way_cfg_seq_pkg.sv
// Shared defaults and helpers for the ISPM way reconfiguration sequencer.
package ispm_way_cfg_seq_pkg;

  localparam int unsigned DefaultNrWays      = 4;
  localparam int unsigned DefaultNrLines     = 256;
  localparam int unsigned DefaultAddrWidth   = 64;
  localparam int unsigned DefaultMemoryWidth = 173;

  function automatic int unsigned be_width(input int unsigned mem_width);
    return (mem_width + 7) / 8;
  endfunction

endpackage

// File: rtl/ispm_way_cfg_seq.sv
// Drains way-memory traffic, zero-sweeps every way whose cache/SPM mode changes,
// then commits the new SPM way mask.
module ispm_way_cfg_seq
  import ispm_way_cfg_seq_pkg::*;
#(
  parameter int unsigned NR_WAYS      = DefaultNrWays,
  parameter int unsigned NR_LINES     = DefaultNrLines,
  parameter int unsigned ADDR_WIDTH   = DefaultAddrWidth,
  parameter int unsigned MEMORY_WIDTH = DefaultMemoryWidth
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     cfg_valid_i,
  input  logic [NR_WAYS-1:0]                       cfg_ways_i,
  output logic                                     cfg_ready_o,
  input  logic                                     idle_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [NR_WAYS-1:0]                       active_ways_o,
  output logic [NR_WAYS-1:0]                       req_o,
  output logic [NR_WAYS*ADDR_WIDTH-1:0]            addr_o,
  output logic [NR_WAYS-1:0]                       we_o,
  output logic [NR_WAYS*MEMORY_WIDTH-1:0]          wdata_o,
  output logic [NR_WAYS*((MEMORY_WIDTH+7)/8)-1:0]  be_o
);

  localparam int unsigned LineWidth = $clog2(NR_LINES);
  localparam int unsigned BeWidth   = be_width(MEMORY_WIDTH);
  localparam logic [LineWidth-1:0] LastLine = LineWidth'(NR_LINES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StSweep,
    StCommit
  } state_e;

  state_e               state_q, state_d;
  logic [LineWidth-1:0] line_q, line_d;
  logic [NR_WAYS-1:0]   target_q, target_d;
  logic [NR_WAYS-1:0]   sweep_q, sweep_d;
  logic [NR_WAYS-1:0]   active_ways_q, active_ways_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      line_q        <= '0;
      target_q      <= '0;
      sweep_q       <= '0;
      active_ways_q <= '0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      target_q      <= target_d;
      sweep_q       <= sweep_d;
      active_ways_q <= active_ways_d;
    end
  end

  // The mask only changes on the last sweep edge, so requesters see the old
  // mapping for the whole drain and sweep.
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    target_d      = target_q;
    sweep_d       = sweep_q;
    active_ways_d = active_ways_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid_i) begin
          target_d = cfg_ways_i;
          sweep_d  = cfg_ways_i ^ active_ways_q;
          state_d  = (sweep_d == '0) ? StCommit : StDrain;
        end
      end
      StDrain: begin
        if (idle_i) begin
          line_d  = '0;
          state_d = StSweep;
        end
      end
      StSweep: begin
        if (line_q == LastLine) begin
          active_ways_d = target_q;
          line_d        = '0;
          state_d       = StCommit;
        end else begin
          line_d = line_q + 1'b1;
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cfg_ready_o = (state_q == StIdle);
    busy_o      = (state_q == StDrain) || (state_q == StSweep);
    done_o      = (state_q == StCommit);
    req_o       = '0;
    we_o        = '0;
    addr_o      = '0;
    wdata_o     = '0;
    be_o        = '0;
    if (state_q == StSweep) begin
      for (int w = 0; w < int'(NR_WAYS); w++) begin
        if (sweep_q[w]) begin
          req_o[w]                               = 1'b1;
          we_o[w]                                = 1'b1;
          addr_o[w*ADDR_WIDTH +: ADDR_WIDTH]     = ADDR_WIDTH'(line_q);
          be_o[w*BeWidth +: BeWidth]             = '1;
        end
      end
    end
  end

  assign active_ways_o = active_ways_q;

endmodule

// File: tb/tb_ispm_way_cfg_seq.sv
// Directed bench for ispm_way_cfg_seq; sweep writes are checked against a scoreboard.
module tb_ispm_way_cfg_seq;

  localparam int NrWays   = 4;
  localparam int NrLines  = 256;
  localparam int AddrW    = 64;
  localparam int MemW     = 173;
  localparam int BeW      = (MemW + 7) / 8;

  typedef struct {
    logic [NrWays-1:0] req;
    int                line;
  } sweep_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    cfg_valid_i;
  logic [NrWays-1:0]       cfg_ways_i;
  logic                    cfg_ready_o;
  logic                    idle_i;
  logic                    busy_o;
  logic                    done_o;
  logic [NrWays-1:0]       active_ways_o;
  logic [NrWays-1:0]       req_o;
  logic [NrWays*AddrW-1:0] addr_o;
  logic [NrWays-1:0]       we_o;
  logic [NrWays*MemW-1:0]  wdata_o;
  logic [NrWays*BeW-1:0]   be_o;

  int                checks   = 0;
  int                failures = 0;
  sweep_t            sb[$];
  logic [NrWays-1:0] modelActive = '0;
  bit                monOn = 0;

  ispm_way_cfg_seq #(
    .NR_WAYS(NrWays), .NR_LINES(NrLines), .ADDR_WIDTH(AddrW), .MEMORY_WIDTH(MemW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ways_i(cfg_ways_i),
    .cfg_ready_o(cfg_ready_o), .idle_i(idle_i), .busy_o(busy_o), .done_o(done_o),
    .active_ways_o(active_ways_o), .req_o(req_o), .addr_o(addr_o), .we_o(we_o),
    .wdata_o(wdata_o), .be_o(be_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offers a mask in the current cycle and queues every line write it should cause.
  task automatic applyStimulus(input logic [NrWays-1:0] mask);
    logic [NrWays-1:0] sw;
    sw = mask ^ modelActive;
    if (sw != '0)
      for (int l = 0; l < NrLines; l++) sb.push_back('{req: sw, line: l});
    checkOutput("ready_before_accept", 768'(cfg_ready_o), 768'(1'b1));
    cfg_valid_i = 1'b1;
    cfg_ways_i  = mask;
  endtask

  // Memory port monitor: pops one scoreboard entry per sweep cycle.
  always @(negedge clk_i) begin
    if (monOn) begin
      if (req_o != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_req", 768'(req_o), 768'(0));
        end else begin
          sweep_t e;
          logic [NrWays*AddrW-1:0] expAddr;
          logic [NrWays*BeW-1:0]   expBe;
          e = sb.pop_front();
          expAddr = '0;
          expBe   = '0;
          for (int w = 0; w < NrWays; w++) begin
            if (e.req[w]) begin
              expAddr[w*AddrW +: AddrW] = AddrW'(e.line);
              expBe[w*BeW +: BeW]       = '1;
            end
          end
          checkOutput($sformatf("req_line%0d", e.line), 768'(req_o), 768'(e.req));
          checkOutput($sformatf("we_line%0d", e.line), 768'(we_o), 768'(e.req));
          checkOutput($sformatf("addr_line%0d", e.line), 768'(addr_o), 768'(expAddr));
          checkOutput($sformatf("be_line%0d", e.line), 768'(be_o), 768'(expBe));
          checkOutput($sformatf("wdata_line%0d", e.line), 768'(wdata_o), 768'(0));
        end
      end else begin
        checkOutput("mem_quiet", 768'((|we_o) | (|addr_o) | (|be_o) | (|wdata_o)), 768'(0));
      end
    end
  end

  // Full reconfiguration: accept, optional drain stall, optional stray valid pulse, commit.
  task automatic runCfg(input logic [NrWays-1:0] mask, input int drainWait, input int pulseAt,
                        input string tag);
    logic [NrWays-1:0] oldActive;
    bit empty, busyOk, heldOk;
    int n, firstReq, expLat;
    oldActive = modelActive;
    empty     = ((mask ^ modelActive) == '0);
    expLat    = empty ? 1 : NrLines + 2 + drainWait;
    busyOk    = 1;
    heldOk    = 1;
    firstReq  = 0;
    idle_i    = (drainWait == 0);
    applyStimulus(mask);
    tick();
    n = 1;
    cfg_valid_i = 1'b0;
    idle_i = (n > drainWait);
    while (done_o !== 1'b1 && n < 2000) begin
      if (req_o != '0 && firstReq == 0) firstReq = n;
      if (busy_o !== 1'b1) busyOk = 0;
      if (active_ways_o !== oldActive) heldOk = 0;
      tick();
      n++;
      idle_i = (n > drainWait);
      if (n == pulseAt) begin
        cfg_valid_i = 1'b1;
        cfg_ways_i  = ~mask;
      end else begin
        cfg_valid_i = 1'b0;
        cfg_ways_i  = mask;
      end
    end
    cfg_valid_i = 1'b0;
    checkOutput({tag, "_done_latency"}, 768'(n), 768'(expLat));
    checkOutput({tag, "_busy_held"}, 768'(busyOk), 768'(1));
    checkOutput({tag, "_old_mask_held"}, 768'(heldOk), 768'(1));
    checkOutput({tag, "_first_write"}, 768'(firstReq), 768'(empty ? 0 : drainWait + 2));
    checkOutput({tag, "_commit_mask"}, 768'(active_ways_o), 768'(mask));
    checkOutput({tag, "_commit_busy"}, 768'(busy_o), 768'(0));
    checkOutput({tag, "_commit_ready"}, 768'(cfg_ready_o), 768'(0));
    tick();
    checkOutput({tag, "_idle_ready"}, 768'(cfg_ready_o), 768'(1));
    checkOutput({tag, "_idle_done"}, 768'(done_o), 768'(0));
    modelActive = mask;
  endtask

  initial begin
    rst_i       = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_ways_i  = '0;
    idle_i      = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    checkOutput("rst_ready", 768'(cfg_ready_o), 768'(1));
    checkOutput("rst_busy", 768'(busy_o), 768'(0));
    checkOutput("rst_done", 768'(done_o), 768'(0));
    checkOutput("rst_active", 768'(active_ways_o), 768'(0));
    checkOutput("rst_req", 768'(req_o), 768'(0));
    checkOutput("rst_mem", 768'((|we_o) | (|addr_o) | (|be_o) | (|wdata_o)), 768'(0));
    monOn = 1;

    runCfg(4'b0011, 0, -1, "first_mask");
    runCfg(4'b0110, 0, -1, "partial_swap");
    runCfg(4'b0110, 0, -1, "same_mask");
    runCfg(4'b1110, 5, -1, "drain_stall");
    runCfg(4'b0111, 0, 50, "ignored_pulse");

    // Abort a sweep at line 100 with reset; nothing may resume afterwards.
    idle_i = 1'b1;
    applyStimulus(4'b1100);
    tick();
    cfg_valid_i = 1'b0;
    repeat (101) tick();
    checkOutput("abort_at_line100", 768'(addr_o[AddrW-1:0]), 768'(100));
    rst_i = 1'b1;
    tick();
    sb.delete();
    checkOutput("abort_ready", 768'(cfg_ready_o), 768'(1));
    checkOutput("abort_busy", 768'(busy_o), 768'(0));
    checkOutput("abort_active", 768'(active_ways_o), 768'(0));
    checkOutput("abort_req", 768'(req_o), 768'(0));
    checkOutput("abort_mem", 768'((|we_o) | (|addr_o) | (|be_o) | (|wdata_o)), 768'(0));
    rst_i = 1'b0;
    modelActive = '0;
    runCfg(4'b0101, 0, -1, "after_abort");

    checkOutput("scoreboard_empty", 768'(sb.size()), 768'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
